vx_tma_dispatch: RTL and testbench
==================================

# vx_tma_dispatch

Per-core front end for the TMA engine. It accepts TMA instructions from the issue/execute pipeline on behalf of any warp and queues them in order. It presents them one at a time to the single-instruction TMA engine and routes the engine's completion event back to the issuing warp. It also maintains a per-warp outstanding-TMA count, which the scheduler uses to stall a warp's TMA wait/fence.

## Interface
Parameters:
- NUM_WARPS, 4: warps sharing the engine; warp id width WIDW = max(1, $clog2(NUM_WARPS)).
- QUEUE_DEPTH, 4: instruction FIFO entries; power of two, ≥ 2.
- REQ_TAGW, 8: engine tag width; must be ≥ WIDW (elaboration assertion).
- CNTW, $clog2(QUEUE_DEPTH+2): per-warp counter width.

Ports:
- clk  in  1  clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  new TMA instruction.
- in_wid  in  WIDW  issuing warp.
- in_desc  in  tma_desc_t  full descriptor.
- in_ready  out  1  queue can accept.
- tma_req_valid  out  1  to engine.
- tma_req_desc  out  tma_desc_t  to engine.
- tma_req_tag  out  REQ_TAGW  zero-extended warp id.
- tma_req_ready  in  1  from engine.
- tma_done_valid  in  1  from engine.
- tma_done_tag  in  REQ_TAGW  from engine.
- tma_done_ready  out  1  to engine.
- cmpl_valid  out  1  completion event to scheduler.
- cmpl_wid  out  WIDW  warp that completed.
- cmpl_ready  in  1  scheduler accepts event.
- warp_pending  out  NUM_WARPS  bit w = warp w has outstanding TMA (count ≠ 0).
- err  out  1  sticky protocol error.

## Operation
- FIFO holds {wid, desc}. Push on in_valid && in_ready. Pop on tma_req_valid && tma_req_ready. in_ready = !full; a push is never accepted into a full FIFO, even when a pop occurs in the same cycle.
- Head drives tma_req_desc and tma_req_tag = REQ_TAGW'(head.wid).
- inflight_r flag: set on the engine request handshake, cleared on the tma_done handshake. tma_req_valid = !empty && !inflight_r. At most one instruction is held by the engine at a time.
- Completion slot: a one-entry register {cmpl_valid, cmpl_wid}.
  - tma_done_ready = !cmpl_valid || cmpl_ready.
  - On a done handshake the slot loads wid = tma_done_tag[WIDW-1:0] and cmpl_valid = 1.
  - The slot clears on cmpl_valid && cmpl_ready when no load occurs in the same cycle.
- Per-warp counter cnt[w] (CNTW bits), covering queued plus in-flight instructions:
  - +1 on push for in_wid.
  - −1 on the done handshake for the tag's warp.
  - Push and done for the same warp in the same cycle: net 0.
  - Push and done for different warps in the same cycle: both apply.
- warp_pending[w] = (cnt[w] != 0), registered from the counter.
- Errors set err = 1 (sticky until reset):
  - Done handshake while inflight_r = 0: counter is not decremented, slot still loads.
  - Done tag warp ≠ wid of the in-flight entry (held in inflight_wid_r).
  - Tag ≥ NUM_WARPS: no counter is changed.
  - Counter underflow: counter held at 0.
- Reset mid-operation: FIFO emptied, all counters cleared, inflight_r and cmpl slot cleared. Any instruction held by the engine is abandoned; the engine shares the same reset.

## Timing
- Reset values: in_ready = 1 from the first cycle after reset. tma_req_valid = 0, tma_done_ready = 1, cmpl_valid = 0, cmpl_wid = 0, warp_pending = 0, err = 0.
- Push to tma_req_valid: 1 cycle. The FIFO is registered with no fall-through.
- Pop to next head valid: the next head is held until the done handshake clears inflight_r. tma_req_valid for the next entry rises the cycle after that handshake.
- Done handshake to cmpl_valid: 1 cycle.
- Push to warp_pending set: 1 cycle. Done handshake to warp_pending clear, when the count reaches 0: 1 cycle.
- cmpl_valid/cmpl_wid stay stable while cmpl_ready = 0. The engine is back-pressured through tma_done_ready.
- The FIFO pointers wrap modulo QUEUE_DEPTH. full/empty are tracked with an extra pointer bit.

## Test plan
- Single instruction: push wid = 2 and complete it.
  - warp_pending = 4'b0100 one cycle after the push.
  - tma_req_tag = 8'h02.
  - The done handshake produces cmpl_valid with cmpl_wid = 2 on the next cycle.
  - warp_pending returns to 0.
- Fill: push 4 entries while tma_req_ready = 0.
  - in_ready = 0 after the 4th push.
  - A 5th in_valid is not accepted.
  - After one pop plus done, in_ready = 1 again.
- Ordering and serialization: push wids 0, 1, 0.
  - Requests are issued in order 0, 1, 0.
  - Each request is issued only after the previous done.
  - cnt[0] goes 1→2→1→0.
  - No second tma_req handshake occurs while inflight.
- Completion backpressure: hold cmpl_ready = 0 with the slot full.
  - tma_done_ready = 0, and the engine's done is held.
  - Asserting cmpl_ready lets both events drain with no loss.
- Simultaneous push and done for the same warp: cnt and warp_pending are unchanged. Push to warp 1 with done for warp 3 in the same cycle: both counters update.
- Errors and reset:
  - Inject a done with inflight_r = 0: err = 1 and counters unchanged.
  - Assert reset with 3 entries queued: the next cycle shows empty, warp_pending = 0, err = 0.

Source files
------------

// File: rtl/vx_tma_pkg.sv
// Shared payload types for the TMA dispatch path.
package vx_tma_pkg;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] gmem_addr;
        logic [31:0] smem_addr;
        logic [15:0] bytes;
    } tma_desc_t;

endpackage

// File: rtl/vx_tma_dispatch.sv
// Per-core TMA front end: in-order instruction queue, single-engine issue,
// completion routing back to the issuing warp and per-warp outstanding counts.
module vx_tma_dispatch
    import vx_tma_pkg::*;
#(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned REQ_TAGW    = 8,
    parameter int unsigned CNTW        = $clog2(QUEUE_DEPTH + 2),
    parameter int unsigned WIDW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 in_valid,
    input  logic [WIDW-1:0]      in_wid,
    input  tma_desc_t            in_desc,
    output logic                 in_ready,

    output logic                 tma_req_valid,
    output tma_desc_t            tma_req_desc,
    output logic [REQ_TAGW-1:0]  tma_req_tag,
    input  logic                 tma_req_ready,

    input  logic                 tma_done_valid,
    input  logic [REQ_TAGW-1:0]  tma_done_tag,
    output logic                 tma_done_ready,

    output logic                 cmpl_valid,
    output logic [WIDW-1:0]      cmpl_wid,
    input  logic                 cmpl_ready,

    output logic [NUM_WARPS-1:0] warp_pending,
    output logic                 err
);

    localparam int unsigned PTRW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    if (REQ_TAGW < WIDW) begin : g_chk_tagw
        $error("vx_tma_dispatch: REQ_TAGW must be >= WIDW");
    end
    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("vx_tma_dispatch: QUEUE_DEPTH must be a power of two >= 2");
    end

    logic [WIDW-1:0]      wid_mem  [QUEUE_DEPTH];
    tma_desc_t            desc_mem [QUEUE_DEPTH];
    logic [PTRW:0]        wr_ptr;
    logic [PTRW:0]        rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    logic                 inflight_r;
    logic [WIDW-1:0]      inflight_wid_r;

    logic                 done_hs;
    logic [WIDW-1:0]      done_wid;
    logic                 done_in_range;
    logic                 done_dec;

    logic [CNTW-1:0]      cnt_r   [NUM_WARPS];
    logic [CNTW-1:0]      cnt_nxt [NUM_WARPS];
    logic [NUM_WARPS-1:0] inc_w;
    logic [NUM_WARPS-1:0] dec_w;
    logic [NUM_WARPS-1:0] pending_nxt;
    logic                 err_nxt;

    // Extra pointer bit distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTRW] != rd_ptr[PTRW]) &&
                      (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // Head is held back while the engine owns an instruction.
    assign tma_req_valid = !empty && !inflight_r;
    assign pop           = tma_req_valid && tma_req_ready;
    assign tma_req_desc  = desc_mem[rd_ptr[PTRW-1:0]];
    assign tma_req_tag   = REQ_TAGW'(wid_mem[rd_ptr[PTRW-1:0]]);

    assign tma_done_ready = !cmpl_valid || cmpl_ready;
    assign done_hs        = tma_done_valid && tma_done_ready;
    assign done_wid       = tma_done_tag[WIDW-1:0];
    assign done_in_range  = {1'b0, tma_done_tag} < (REQ_TAGW + 1)'(NUM_WARPS);
    assign done_dec       = done_hs && inflight_r && done_in_range;

    // Queue storage carries no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            wid_mem[wr_ptr[PTRW-1:0]]  <= in_wid;
            desc_mem[wr_ptr[PTRW-1:0]] <= in_desc;
        end
    end

    always_comb begin
        inc_w = '0;
        dec_w = '0;
        if (push) begin
            inc_w[in_wid] = 1'b1;
        end
        if (done_dec) begin
            dec_w[done_wid] = 1'b1;
        end
    end

    // Counter next state; a same-warp push and done cancel out.
    always_comb begin
        err_nxt     = err;
        pending_nxt = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_nxt[w] = cnt_r[w];
            if (inc_w[w] && !dec_w[w]) begin
                cnt_nxt[w] = cnt_r[w] + CNTW'(1);
            end else if (dec_w[w] && !inc_w[w]) begin
                if (cnt_r[w] == '0) begin
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt[w] = cnt_r[w] - CNTW'(1);
                end
            end
            pending_nxt[w] = (cnt_nxt[w] != '0);
        end
        if (done_hs && (!inflight_r || !done_in_range ||
                        (tma_done_tag != REQ_TAGW'(inflight_wid_r)))) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= cnt_nxt[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            inflight_r     <= 1'b0;
            inflight_wid_r <= '0;
            cmpl_valid     <= 1'b0;
            cmpl_wid       <= '0;
            warp_pending   <= '0;
            err            <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTRW + 1)'(1);
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + (PTRW + 1)'(1);
                inflight_r     <= 1'b1;
                inflight_wid_r <= wid_mem[rd_ptr[PTRW-1:0]];
            end else if (done_hs) begin
                inflight_r <= 1'b0;
            end
            // A new completion takes priority over draining the slot.
            if (done_hs) begin
                cmpl_valid <= 1'b1;
                cmpl_wid   <= done_wid;
            end else if (cmpl_ready) begin
                cmpl_valid <= 1'b0;
            end
            warp_pending <= pending_nxt;
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vx_tma_dispatch.sv
// Bench for vx_tma_dispatch: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_vx_tma_dispatch;
    import vx_tma_pkg::*;

    localparam int unsigned NW   = 4;
    localparam int unsigned QD   = 4;
    localparam int unsigned TW   = 8;
    localparam int unsigned WIDW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [WIDW-1:0] in_wid;
    tma_desc_t       in_desc;
    logic            in_ready;
    logic            tma_req_valid;
    tma_desc_t       tma_req_desc;
    logic [TW-1:0]   tma_req_tag;
    logic            tma_req_ready;
    logic            tma_done_valid;
    logic [TW-1:0]   tma_done_tag;
    logic            tma_done_ready;
    logic            cmpl_valid;
    logic [WIDW-1:0] cmpl_wid;
    logic            cmpl_ready;
    logic [NW-1:0]   warp_pending;
    logic            err;

    vx_tma_dispatch #(.NUM_WARPS(NW), .QUEUE_DEPTH(QD), .REQ_TAGW(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_wid(in_wid), .in_desc(in_desc), .in_ready(in_ready),
        .tma_req_valid(tma_req_valid), .tma_req_desc(tma_req_desc),
        .tma_req_tag(tma_req_tag), .tma_req_ready(tma_req_ready),
        .tma_done_valid(tma_done_valid), .tma_done_tag(tma_done_tag),
        .tma_done_ready(tma_done_ready),
        .cmpl_valid(cmpl_valid), .cmpl_wid(cmpl_wid), .cmpl_ready(cmpl_ready),
        .warp_pending(warp_pending), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int        m_q_wid[$];
    tma_desc_t m_q_desc[$];
    bit        m_inflight = 0;
    int        m_inflight_wid = 0;
    bit        m_cv = 0;
    int        m_cw = 0;
    int        m_cnt[NW];
    bit        m_err = 0;
    bit        last_dhs = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tma_desc_t rand_desc();
        tma_desc_t d;
        d.opcode    = 4'($urandom);
        d.gmem_addr = $urandom;
        d.smem_addr = $urandom;
        d.bytes     = 16'($urandom);
        return d;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        bit push, pop, dhs;
        int tag;
        int delta[NW];
        last_dhs = 0;
        if (reset) begin
            m_q_wid.delete();
            m_q_desc.delete();
            m_inflight = 0; m_inflight_wid = 0;
            m_cv = 0; m_cw = 0; m_err = 0;
            foreach (m_cnt[w]) m_cnt[w] = 0;
            return;
        end
        push = in_valid && (m_q_wid.size() < QD);
        pop  = (m_q_wid.size() > 0) && !m_inflight && tma_req_ready;
        dhs  = tma_done_valid && (!m_cv || cmpl_ready);
        tag  = int'(tma_done_tag);
        foreach (delta[w]) delta[w] = 0;
        if (push) delta[in_wid]++;
        if (dhs) begin
            if (!m_inflight || tag != m_inflight_wid || tag >= NW) m_err = 1;
            if (m_inflight && tag < NW) delta[tag]--;
        end
        foreach (m_cnt[w]) begin
            if (m_cnt[w] + delta[w] < 0) m_err = 1;
            else m_cnt[w] += delta[w];
        end
        if (dhs) m_inflight = 0;
        if (pop) begin
            m_inflight     = 1;
            m_inflight_wid = m_q_wid.pop_front();
            void'(m_q_desc.pop_front());
        end
        if (dhs) begin
            m_cv = 1;
            m_cw = tag % NW;
        end else if (cmpl_ready) begin
            m_cv = 0;
        end
        if (push) begin
            m_q_wid.push_back(int'(in_wid));
            m_q_desc.push_back(in_desc);
        end
        last_dhs = dhs;
    endtask

    task automatic check_model();
        logic [NW-1:0] pend;
        bit            rv;
        for (int w = 0; w < NW; w++) pend[w] = (m_cnt[w] != 0);
        rv = (m_q_wid.size() > 0) && !m_inflight;
        chk("in_ready", 128'(in_ready), 128'(m_q_wid.size() < QD));
        chk("req_valid", 128'(tma_req_valid), 128'(rv));
        if (rv) begin
            chk("req_tag", 128'(tma_req_tag), 128'(m_q_wid[0]));
            chk("req_desc", 128'(tma_req_desc), 128'(m_q_desc[0]));
        end
        chk("done_ready", 128'(tma_done_ready), 128'(!m_cv || cmpl_ready));
        chk("cmpl_valid", 128'(cmpl_valid), 128'(m_cv));
        if (m_cv) chk("cmpl_wid", 128'(cmpl_wid), 128'(m_cw));
        chk("warp_pending", 128'(warp_pending), 128'(pend));
        chk("err", 128'(err), 128'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    initial begin
        int order[3];
        order[0] = 0; order[1] = 1; order[2] = 0;

        reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_desc = '0;
        tma_req_ready = 1'b0; tma_done_valid = 1'b0; tma_done_tag = '0; cmpl_ready = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_done_ready", 128'(tma_done_ready), 128'(1));

        // Single instruction from warp 2
        in_valid = 1'b1; in_wid = 2'd2; in_desc = rand_desc();
        cycle();
        in_valid = 1'b0;
        chk("single_pending", 128'(warp_pending), 128'(4'b0100));
        chk("single_tag", 128'(tma_req_tag), 128'(8'h02));
        tma_req_ready = 1'b1; cycle();
        tma_req_ready = 1'b0; tma_done_valid = 1'b1; tma_done_tag = 8'd2; cycle();
        tma_done_valid = 1'b0;
        chk("single_cmpl_valid", 128'(cmpl_valid), 128'(1));
        chk("single_cmpl_wid", 128'(cmpl_wid), 128'(2));
        chk("single_pending_clr", 128'(warp_pending), 128'(0));
        cycle();

        // Fill with the engine stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_wid = WIDW'(i); in_desc = rand_desc();
            cycle();
        end
        chk("fill_full", 128'(in_ready), 128'(0));
        in_wid = 2'd1; in_desc = rand_desc(); cycle();
        in_valid = 1'b0;
        chk("fill_no_5th", 128'(warp_pending), 128'(4'b1111));
        tma_req_ready = 1'b1; cycle();
        tma_req_ready = 1'b0; tma_done_valid = 1'b1; tma_done_tag = 8'd0; cycle();
        tma_done_valid = 1'b0;
        chk("fill_ready_again", 128'(in_ready), 128'(1));
        cycle();

        // Done with nothing in flight, then reset with 3 queued
        tma_done_valid = 1'b1; tma_done_tag = 8'd1; cycle();
        tma_done_valid = 1'b0;
        chk("stray_err", 128'(err), 128'(1));
        chk("stray_cnt", 128'(warp_pending), 128'(4'b1110));
        reset = 1'b1; cycle();
        reset = 1'b0;
        chk("reset_req_valid", 128'(tma_req_valid), 128'(0));
        chk("reset_pending", 128'(warp_pending), 128'(0));
        chk("reset_err", 128'(err), 128'(0));

        // Ordering and serialization: wids 0, 1, 0
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_wid = WIDW'(order[i]); in_desc = rand_desc();
            cycle();
        end
        in_valid = 1'b0;
        tma_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ord_valid", 128'(tma_req_valid), 128'(1));
            chk("ord_tag", 128'(tma_req_tag), 128'(order[i]));
            cycle();
            repeat (2) begin
                cycle();
                chk("ord_serial", 128'(tma_req_valid), 128'(0));
            end
            tma_done_valid = 1'b1; tma_done_tag = TW'(order[i]); cycle();
            tma_done_valid = 1'b0;
        end
        tma_req_ready = 1'b0;
        chk("ord_pending_clr", 128'(warp_pending), 128'(0));
        cycle();

        // Completion backpressure
        cmpl_ready = 1'b0; tma_req_ready = 1'b1;
        in_valid = 1'b1; in_wid = 2'd3; in_desc = rand_desc(); cycle();
        in_wid = 2'd1; in_desc = rand_desc(); cycle();
        in_valid = 1'b0; tma_done_valid = 1'b1; tma_done_tag = 8'd3; cycle();
        tma_done_valid = 1'b0; cycle();
        tma_req_ready = 1'b0; tma_done_valid = 1'b1; tma_done_tag = 8'd1;
        chk("bp_done_ready", 128'(tma_done_ready), 128'(0));
        cycle(); cycle();
        chk("bp_hold_wid", 128'(cmpl_wid), 128'(3));
        cmpl_ready = 1'b1; cycle();
        tma_done_valid = 1'b0;
        chk("bp_second_valid", 128'(cmpl_valid), 128'(1));
        chk("bp_second_wid", 128'(cmpl_wid), 128'(1));
        cycle();
        chk("bp_drained", 128'(cmpl_valid), 128'(0));

        // Same-cycle push and done, same warp then different warps
        in_valid = 1'b1; in_wid = 2'd2; in_desc = rand_desc(); cycle();
        in_valid = 1'b0; tma_req_ready = 1'b1; cycle();
        tma_req_ready = 1'b0;
        in_valid = 1'b1; in_wid = 2'd2; in_desc = rand_desc();
        tma_done_valid = 1'b1; tma_done_tag = 8'd2; cycle();
        in_valid = 1'b0; tma_done_valid = 1'b0;
        chk("same_warp_net0", 128'(warp_pending), 128'(4'b0100));
        tma_req_ready = 1'b1; cycle();
        tma_req_ready = 1'b0; tma_done_valid = 1'b1; tma_done_tag = 8'd2; cycle();
        tma_done_valid = 1'b0;
        in_valid = 1'b1; in_wid = 2'd3; in_desc = rand_desc(); cycle();
        in_valid = 1'b0; tma_req_ready = 1'b1; cycle();
        tma_req_ready = 1'b0;
        in_valid = 1'b1; in_wid = 2'd1; in_desc = rand_desc();
        tma_done_valid = 1'b1; tma_done_tag = 8'd3; cycle();
        in_valid = 1'b0; tma_done_valid = 1'b0;
        chk("diff_warp_both", 128'(warp_pending), 128'(4'b0010));

        // Random traffic with an engine that serves in-flight work
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(99) == 0);
            in_valid      = 1'($urandom_range(1));
            in_wid        = WIDW'($urandom_range(NW - 1));
            in_desc       = rand_desc();
            tma_req_ready = 1'($urandom_range(1));
            cmpl_ready    = ($urandom_range(3) != 0);
            if (!(tma_done_valid && !last_dhs && m_inflight &&
                  int'(tma_done_tag) == m_inflight_wid)) begin
                if (m_inflight && $urandom_range(2) == 0) begin
                    tma_done_valid = 1'b1;
                    tma_done_tag   = TW'(m_inflight_wid);
                end else if (!m_inflight && $urandom_range(39) == 0) begin
                    tma_done_valid = 1'b1;
                    tma_done_tag   = TW'($urandom_range(7));
                end else begin
                    tma_done_valid = 1'b0;
                end
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
